// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect sequencer.
// Holds the default sizing parameters, the sequencer FSM state encoding
// and a small width helper used for counters and indices.
package audio_fx_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 16;
  localparam int unsigned NUM_EFFECTS_DEF    = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 900;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SELECT    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } seq_state_t;

  // Bits needed to represent values 0..n-1, never less than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/effect_sequencer_if.sv
// Effect-slot bus between the sequencer (master) and the effect units (slave).
//   fx_cs       : per-slot chip select
//   fx_my_turn  : one-hot grant to the slot currently processing
//   fx_data_in  : shared sample bus driven to every slot
//   fx_done     : per-slot completion pulse
//   fx_data_out : packed per-slot results, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
interface effect_sequencer_if
  import audio_fx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned NUM_EFFECTS = NUM_EFFECTS_DEF
);
  logic [NUM_EFFECTS-1:0]            fx_cs;
  logic [NUM_EFFECTS-1:0]            fx_my_turn;
  logic [DATA_WIDTH-1:0]             fx_data_in;
  logic [NUM_EFFECTS-1:0]            fx_done;
  logic [NUM_EFFECTS*DATA_WIDTH-1:0] fx_data_out;

  modport master (
    output fx_cs, fx_my_turn, fx_data_in,
    input  fx_done, fx_data_out
  );

  modport slave (
    input  fx_cs, fx_my_turn, fx_data_in,
    output fx_done, fx_data_out
  );
endinterface

// File: rtl/fx_watchdog.sv
// Per-slot watchdog for the effect sequencer.
//   clk, rst : clock, synchronous active-high reset
//   start    : arm and restart the count from zero
//   done     : disarm (slot finished or bypassed)
//   expired  : armed and the count has reached TIMEOUT_CYCLES-1
// The counter saturates at its all-ones value and never wraps.
module fx_watchdog
  import audio_fx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done,
  output logic expired
);
  localparam int unsigned   TW   = width_for(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_armed <= 1'b0;
    end else if (start) begin
      r_timer <= '0;
      r_armed <= 1'b1;
    end else if (done) begin
      r_armed <= 1'b0;
    end else if (r_armed && (r_timer != '1)) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign expired = r_armed && (r_timer == LAST);
endmodule

// File: rtl/effect_sequencer.sv
// Audio effect chain sequencer.
// Each accepted codec sample is walked through the enabled effect slots in
// order (slot 0 first). An enabled slot is granted the shared bus and the
// sequencer waits for its done pulse or for the watchdog; a timed-out slot
// is bypassed and flagged. The final value leaves on sample_out.
//   clk, rst          : clock, synchronous active-high reset
//   sample_in/_valid  : codec input sample and one-cycle strobe
//   fx_enable         : per-slot enables, snapshotted per sample
//   fx                : effect-slot bus (master side)
//   sample_out/_valid : processed sample and one-cycle strobe
//   flags_clear       : clears the sticky flags
//   overrun           : sticky, a sample arrived while busy and was dropped
//   timeout_flags     : sticky, per-slot watchdog expiry
module effect_sequencer
  import audio_fx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned NUM_EFFECTS    = NUM_EFFECTS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  sample_in,
  input  logic                   sample_valid,
  input  logic [NUM_EFFECTS-1:0] fx_enable,
  effect_sequencer_if.master     fx,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_out_valid,
  input  logic                   flags_clear,
  output logic                   overrun,
  output logic [NUM_EFFECTS-1:0] timeout_flags
);
  // idx must reach NUM_EFFECTS to mark the end of the chain
  localparam int unsigned IW = width_for(NUM_EFFECTS + 1);

  seq_state_t             r_state,   w_state_nxt;
  logic [IW-1:0]          r_idx,     w_idx_nxt;
  logic [DATA_WIDTH-1:0]  r_work,    w_work_nxt;
  logic [NUM_EFFECTS-1:0] r_en_snap, w_en_nxt;
  logic [NUM_EFFECTS-1:0] r_my_turn, w_turn_nxt;
  logic [DATA_WIDTH-1:0]  r_sample_out, w_out_nxt;
  logic                   r_out_valid,  w_out_valid_nxt;
  logic                   r_overrun;
  logic [NUM_EFFECTS-1:0] r_timeout;

  logic                   w_slot_en;
  logic                   w_slot_done;
  logic [DATA_WIDTH-1:0]  w_slot_data;
  logic [NUM_EFFECTS-1:0] w_slot_hot;
  logic                   w_wd_start;
  logic                   w_wd_done;
  logic                   w_expired;
  logic                   w_overrun_set;
  logic [NUM_EFFECTS-1:0] w_to_set;

  fx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (w_wd_start),
    .done   (w_wd_done),
    .expired(w_expired)
  );

  // Decode the slot addressed by idx; idx == NUM_EFFECTS selects nothing.
  always_comb begin
    w_slot_en   = 1'b0;
    w_slot_done = 1'b0;
    w_slot_data = '0;
    w_slot_hot  = '0;
    for (int unsigned k = 0; k < NUM_EFFECTS; k++) begin
      if (r_idx == IW'(k)) begin
        w_slot_en     = r_en_snap[k];
        w_slot_done   = fx.fx_done[k];
        w_slot_data   = fx.fx_data_out[k*DATA_WIDTH +: DATA_WIDTH];
        w_slot_hot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_work_nxt      = r_work;
    w_en_nxt        = r_en_snap;
    w_turn_nxt      = r_my_turn;
    w_out_nxt       = r_sample_out;
    w_out_valid_nxt = 1'b0;
    w_wd_start      = 1'b0;
    w_wd_done       = 1'b0;
    w_to_set        = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (sample_valid) begin
          w_work_nxt  = sample_in;
          w_en_nxt    = fx_enable;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (r_idx == IW'(NUM_EFFECTS)) begin
          w_out_nxt       = r_work;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else if (w_slot_en) begin
          w_turn_nxt  = w_slot_hot;
          w_wd_start  = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      ST_WAIT_DONE: begin
        // A done pulse in the expiry cycle still delivers the result.
        if (w_slot_done) begin
          w_work_nxt  = w_slot_data;
          w_turn_nxt  = '0;
          w_idx_nxt   = r_idx + IW'(1);
          w_wd_done   = 1'b1;
          w_state_nxt = ST_SELECT;
        end else if (w_expired) begin
          w_to_set    = w_slot_hot;
          w_turn_nxt  = '0;
          w_idx_nxt   = r_idx + IW'(1);
          w_wd_done   = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_overrun_set = sample_valid && (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_work       <= '0;
      r_en_snap    <= '0;
      r_my_turn    <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_work       <= w_work_nxt;
      r_en_snap    <= w_en_nxt;
      r_my_turn    <= w_turn_nxt;
      r_sample_out <= w_out_nxt;
      r_out_valid  <= w_out_valid_nxt;
      // set events take priority over a same-cycle clear
      r_overrun    <= (flags_clear ? 1'b0 : r_overrun) | w_overrun_set;
      r_timeout    <= (flags_clear ? '0 : r_timeout) | w_to_set;
    end
  end

  assign fx.fx_data_in   = r_work;
  assign fx.fx_my_turn   = r_my_turn;
  assign fx.fx_cs        = (r_state == ST_IDLE) ? fx_enable : r_en_snap;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_out_valid;
  assign overrun          = r_overrun;
  assign timeout_flags    = r_timeout;
endmodule
